fifo_rd_packer: RTL and testbench

- Read-side drain stage placed directly downstream of the async FIFO, in the FIFO's read clock domain.
- Pops bytes through the FIFO's rd_en/f_empty/data_out interface and packs PACK consecutive bytes into one wide word.
- Presents each word on a valid/ready master interface.
- A flush request forces out a partial word so tail data is never stranded.

---
 rtl/fifo_rd_packer.sv | 82 ++++++++
 tb/tb_fifo_rd_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the read side of an async FIFO and packs PACK bytes per output word
// on a valid/ready master port, with a flush path that emits a partial tail word.
module fifo_rd_packer #(
    parameter int DATAWIDTH = 8,
    parameter int PACK      = 4,
    parameter int CNTW      = 3
) (
    input  logic                      rd_clk,
    input  logic                      rst,
    input  logic                      f_empty,
    input  logic [DATAWIDTH-1:0]      data_in,
    output logic                      rd_en,
    input  logic                      flush,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [PACK*DATAWIDTH-1:0] m_data,
    output logic [CNTW-1:0]           m_cnt,
    output logic                      m_last,
    output logic                      busy
);
    typedef enum logic [1:0] {RUN, FLUSH_DRAIN, FLUSH_EMIT} state_t;
    state_t                    state;
    logic [CNTW-1:0]           pack_cnt;
    logic                      inflight;
    logic                      flush_pend;
    logic                      out_ok;
    logic [CNTW:0]             lane_sum;
    logic [PACK*DATAWIDTH-1:0] pack_reg;

    assign flush_pend = state != RUN;
    assign out_ok     = !m_valid || m_ready;
    // lane_sum only equals PACK when the wrapped target lane is 0, so comparing unwrapped is enough
    assign lane_sum   = {1'b0, pack_cnt} + (CNTW+1)'(inflight);
    assign rd_en      = rst && !f_empty && !flush_pend && (lane_sum != (CNTW+1)'(PACK-1) || out_ok);
    assign busy       = pack_cnt != '0 || inflight || flush_pend || m_valid;

    always_ff @(posedge rd_clk) begin
        if (!rst) begin
            state    <= RUN;
            pack_cnt <= '0;
            inflight <= 1'b0;
            pack_reg <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_cnt    <= '0;
            m_last   <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (m_ready)
                m_valid <= 1'b0;
            if (inflight) begin
                if (pack_cnt == CNTW'(PACK-1)) begin
                    m_data   <= {data_in, pack_reg[(PACK-1)*DATAWIDTH-1:0]};
                    m_cnt    <= CNTW'(PACK);
                    m_last   <= 1'b0;
                    m_valid  <= 1'b1;
                    pack_cnt <= '0;
                    pack_reg <= '0;
                end else begin
                    pack_reg[pack_cnt*DATAWIDTH +: DATAWIDTH] <= data_in;
                    pack_cnt <= pack_cnt + 1'b1;
                end
            end
            case (state)
                RUN:         if (flush) state <= FLUSH_DRAIN;
                FLUSH_DRAIN: if (!inflight) state <= (pack_cnt == '0) ? RUN : FLUSH_EMIT;
                FLUSH_EMIT: begin
                    if (out_ok) begin
                        m_data   <= pack_reg;
                        m_cnt    <= pack_cnt;
                        m_last   <= 1'b1;
                        m_valid  <= 1'b1;
                        pack_cnt <= '0;
                        pack_reg <= '0;
                        state    <= RUN;
                    end
                end
                default:     state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and randomized checks of fifo_rd_packer against a FIFO model
// and a byte-stream scoreboard that groups pushed bytes into expected words.
module tb_fifo_rd_packer;
    localparam int DW = 8, PACK = 4, CNTW = 3;

    logic             rd_clk = 1'b0, rst = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic             f_empty, rd_en, m_valid, m_last, busy;
    logic [DW-1:0]    data_in = '0;
    logic [PACK*DW-1:0] m_data;
    logic [CNTW-1:0]  m_cnt;

    logic [7:0] mem [0:4095];
    int wr_ptr = 0, rd_ptr = 0;
    typedef struct {logic [31:0] data; int cnt; bit last;} word_t;
    word_t      exp_q[$];
    logic [7:0] partial[$];
    word_t      mon_w;
    int passed = 0, failed = 0, total = 0, xfers = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_packer #(.DATAWIDTH(DW), .PACK(PACK), .CNTW(CNTW)) dut (
        .rd_clk(rd_clk), .rst(rst), .f_empty(f_empty), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_cnt(m_cnt), .m_last(m_last), .busy(busy)
    );

    // FIFO model: data appears one cycle after the pop request
    assign f_empty = wr_ptr == rd_ptr;
    always @(posedge rd_clk)
        if (rd_en) begin
            data_in <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic emit(input bit last);
        word_t w;
        w.data = '0;
        foreach (partial[i]) w.data |= 32'(partial[i]) << (8 * i);
        w.cnt  = partial.size();
        w.last = last;
        exp_q.push_back(w);
        partial.delete();
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
        partial.push_back(b);
        if (partial.size() == PACK) emit(1'b0);
    endtask

    task automatic cut();
        if (partial.size() > 0) emit(1'b1);
    endtask

    task automatic do_flush();
        cut();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (busy || !f_empty); i++) cyc();
        chk(tag, {busy, f_empty}, 2'b01);
    endtask

    always @(negedge rd_clk)
        if (rst && m_valid && m_ready) begin
            xfers++;
            chk("word_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                chk("sb_data", m_data, mon_w.data);
                chk("sb_cnt", 32'(m_cnt), mon_w.cnt);
                chk("sb_last", 32'(m_last), 32'(mon_w.last));
            end
        end

    initial begin
        int n, x0;
        logic [15:0] rmask, vmask;
        m_ready = 1'b1;
        repeat (3) cyc();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_cnt", m_cnt, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        #1;
        chk("t1_first_pop", rd_en, 1);
        rmask = '0; vmask = '0;
        for (int i = 0; i < 10; i++) begin
            rmask[i] = rd_en;
            vmask[i] = m_valid;
            if (i == 5) begin
                chk("t1_data", m_data, 32'h44332211);
                chk("t1_cnt", m_cnt, 4);
                chk("t1_last", m_last, 0);
            end
            cyc();
        end
        chk("t1_pop_mask", rmask, 16'h000F);
        chk("t1_valid_mask", vmask, 16'h0020);
        wait_idle("t1_idle");

        for (int b = 1; b <= 12; b++) push(8'(b));
        #1;
        rmask = '0; vmask = '0;
        for (int i = 0; i < 16; i++) begin
            rmask[i] = rd_en;
            vmask[i] = m_valid;
            cyc();
        end
        chk("t2_pop_mask", rmask, 16'h0FFF);
        chk("t2_valid_mask", vmask, 16'h2220);
        wait_idle("t2_idle");

        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) push(8'h81 + 8'(b));
        #1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            n += int'(rd_en);
            if (m_valid) chk("t3_hold", m_data, 32'h84838281);
            cyc();
        end
        chk("t3_pops", n, 7);
        chk("t3_stalled", rd_en, 0);
        chk("t3_valid", m_valid, 1);
        m_ready = 1'b1;
        #1;
        chk("t3_resume", rd_en, 1);
        wait_idle("t3_idle");

        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (6) cyc();
        chk("t4_no_word", m_valid, 0);
        do_flush();
        for (int i = 0; i < 10 && !m_valid; i++) cyc();
        chk("t4_valid", m_valid, 1);
        chk("t4_data", m_data, 32'h00A3A2A1);
        chk("t4_cnt", m_cnt, 3);
        chk("t4_last", m_last, 1);
        cyc();
        chk("t4_busy", busy, 0);

        x0 = xfers;
        do_flush();
        chk("t5_pend", busy, 1);
        cyc();
        chk("t5_clear", busy, 0);
        chk("t5_no_valid", m_valid, 0);
        chk("t5_no_xfer", xfers - x0, 0);
        push(8'hB1);
        repeat (4) cyc();
        push(8'hB2);
        cut();
        flush = 1'b1;
        #1;
        chk("t5_pop_with_flush", rd_en, 1);
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) cyc();
        chk("t5_cnt", m_cnt, 2);
        chk("t5_data", m_data, 32'h0000B2B1);
        wait_idle("t5_idle");

        m_ready = 1'b0;
        for (int b = 0; b < 6; b++) push(8'hC1 + 8'(b));
        repeat (12) cyc();
        chk("t6_pre_valid", m_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        exp_q.delete();
        partial.delete();
        cyc();
        chk("t6_m_valid", m_valid, 0);
        chk("t6_m_data", m_data, 0);
        chk("t6_m_cnt", m_cnt, 0);
        chk("t6_m_last", m_last, 0);
        chk("t6_rd_en", rd_en, 0);
        chk("t6_busy", busy, 0);
        rst = 1'b1;
        m_ready = 1'b1;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        wait_idle("t6_idle");

        for (int s = 0; s < 6; s++) begin
            push(8'($urandom));
            for (int i = 0; i < 40; i++) begin
                m_ready = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 2) == 0) push(8'($urandom));
                cyc();
            end
            for (int i = 0; i < 300 && !f_empty; i++) begin
                m_ready = $urandom_range(0, 3) != 0;
                cyc();
            end
            chk("rnd_drained", f_empty, 1);
            do_flush();
        end
        m_ready = 1'b1;
        wait_idle("final_idle");
        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
